// File: rtl/cla_sub_serial.sv
// cla_sub_serial: digit-serial subtractor computing (a - b - bin) mod 2^W,
// one 4-bit digit per clock, least-significant digit first. Each digit is
// formed with a 4-bit carry-lookahead adder (a + ~b + carry), and the carry
// is registered between digits. It produces unsigned borrow-out, signed
// overflow and zero flags, with a valid/ready handshake on each side.
module cla_sub_serial #(
  parameter int WIDTH_DIV_4 = 16,
  localparam int W  = 4 * WIDTH_DIV_4,
  localparam int CW = (WIDTH_DIV_4 > 1) ? $clog2(WIDTH_DIV_4) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         bout,
  output logic         overflow,
  output logic         zero,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, b_reg, result_reg;
  logic [CW-1:0]  count_reg;
  logic           carry_reg;
  logic           bout_reg, overflow_reg, zero_reg;

  // Digit currently being processed, selected by the digit counter
  logic [3:0]     a_dig [WIDTH_DIV_4];
  logic [3:0]     b_dig [WIDTH_DIV_4];
  logic [3:0]     a_cur, b_cur;

  // Carry-lookahead terms for a + ~b + carry_in
  logic [3:0]     bn, g, p, sum;
  logic [4:0]     c;

  logic [W-1:0]   result_upd;
  logic           last_digit;
  logic           accept;

  // Slice the latched operands into addressable digits
  for (genvar gi = 0; gi < WIDTH_DIV_4; gi++) begin : g_digits
    assign a_dig[gi] = a_reg[4*gi +: 4];
    assign b_dig[gi] = b_reg[4*gi +: 4];
  end

  assign a_cur = a_dig[count_reg];
  assign b_cur = b_dig[count_reg];

  // Subtraction as addition of the one's complement; the initial carry is ~bin
  assign bn   = ~b_cur;
  assign g    = a_cur & bn;
  assign p    = a_cur ^ bn;
  assign c[0] = carry_reg;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sum  = p ^ c[3:0];

  // Accumulator with the current digit's sum written into its slot
  for (genvar gi = 0; gi < WIDTH_DIV_4; gi++) begin : g_result
    localparam logic [CW-1:0] IDX = CW'(gi);
    assign result_upd[4*gi +: 4] = (count_reg == IDX) ? sum : result_reg[4*gi +: 4];
  end

  assign last_digit = (count_reg == CW'(WIDTH_DIV_4 - 1));
  assign accept     = (state_reg == IDLE) && in_valid;

  // State register; reset returns to IDLE without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: no bypass from DONE straight into a new operation
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand capture, per-digit accumulation and flag registration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      result_reg   <= '0;
      count_reg    <= '0;
      carry_reg    <= 1'b0;
      bout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (accept) begin
      a_reg        <= a;
      b_reg        <= b;
      carry_reg    <= ~bin;
      result_reg   <= '0;
      count_reg    <= '0;
      bout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (state_reg == RUN) begin
      result_reg <= result_upd;
      carry_reg  <= c[4];
      if (last_digit) begin
        // Final digit: sum[3] is the result sign bit
        bout_reg     <= ~c[4];
        overflow_reg <= (a_reg[W-1] != b_reg[W-1]) && (sum[3] != a_reg[W-1]);
        zero_reg     <= (result_upd == '0);
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign result   = result_reg;
  assign bout     = bout_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;

endmodule

// File: tb/tb_cla_sub_serial.sv
// Bench for cla_sub_serial: three instances (16, 2 and 1 digits) checked
// against an arithmetic reference model, plus directed literal vectors.
module tb_cla_sub_serial;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [63:0] a_s [3];
  logic [63:0] b_s [3];
  logic        bin_s [3];
  logic        iv [3];
  logic        ordy [3];
  logic        ir_s [3];
  logic        ov_s [3];
  logic        bo_s [3];
  logic        of_s [3];
  logic        z_s [3];
  logic        busy_s [3];
  logic [63:0] res_s [3];
  wire  [63:0] r0;
  wire  [7:0]  r1;
  wire  [3:0]  r2;

  assign res_s[0] = r0;
  assign res_s[1] = {56'd0, r1};
  assign res_s[2] = {60'd0, r2};

  int checks = 0;
  int failures = 0;
  int mode [3];                 // 0: out_ready=1, 1: random, 2: held low
  logic [67:0] exp_q [3][$];    // {zero, overflow, bout, result}

  cla_sub_serial #(.WIDTH_DIV_4(16)) u_w16 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir_s[0]),
    .a(a_s[0]), .b(b_s[0]), .bin(bin_s[0]), .out_valid(ov_s[0]),
    .out_ready(ordy[0]), .result(r0), .bout(bo_s[0]), .overflow(of_s[0]),
    .zero(z_s[0]), .busy(busy_s[0]));

  cla_sub_serial #(.WIDTH_DIV_4(2)) u_w2 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir_s[1]),
    .a(a_s[1][7:0]), .b(b_s[1][7:0]), .bin(bin_s[1]), .out_valid(ov_s[1]),
    .out_ready(ordy[1]), .result(r1), .bout(bo_s[1]), .overflow(of_s[1]),
    .zero(z_s[1]), .busy(busy_s[1]));

  cla_sub_serial #(.WIDTH_DIV_4(1)) u_w1 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir_s[2]),
    .a(a_s[2][3:0]), .b(b_s[2][3:0]), .bin(bin_s[2]), .out_valid(ov_s[2]),
    .out_ready(ordy[2]), .result(r2), .bout(bo_s[2]), .overflow(of_s[2]),
    .zero(z_s[2]), .busy(busy_s[2]));

  function automatic int width_of(int k);
    case (k)
      0:       return 64;
      1:       return 8;
      default: return 4;
    endcase
  endfunction

  // Reference: plain unsigned and signed arithmetic on w-bit operands
  function automatic logic [67:0] model(int w, logic [63:0] a, logic [63:0] b, logic bin);
    logic [63:0] mask, av, bv, res;
    logic [64:0] full;
    logic        bo, ovf;
    logic signed [66:0] sa, sb, sbin, diff, lim;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    av   = a & mask;
    bv   = b & mask;
    full = {1'b0, av} - {1'b0, bv} - {64'd0, bin};
    res  = full[63:0] & mask;
    bo   = ({1'b0, av} < ({1'b0, bv} + {64'd0, bin}));
    lim  = 67'sd1 <<< (w - 1);
    sa   = $signed({3'b000, av});
    if (av[w-1]) sa = sa - (lim <<< 1);
    sb   = $signed({3'b000, bv});
    if (bv[w-1]) sb = sb - (lim <<< 1);
    sbin = bin ? 67'sd1 : 67'sd0;
    diff = sa - sb - sbin;
    ovf  = (diff >= lim) || (diff < -lim);
    return {(res == 64'd0), ovf, bo, res};
  endfunction

  task automatic chk(string name, logic [67:0] act, logic [67:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // out_ready driver, updated shortly after each rising edge
  always @(posedge clk) begin
    #3;
    for (int k = 0; k < 3; k++)
      ordy[k] = (mode[k] == 0) ? 1'b1 : (mode[k] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Compare process: every cycle a result is presented it must match the model
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int k = 0; k < 3; k++) begin
        if (ov_s[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid k=%0d: actual=1 required=0", k);
          end else begin
            chk($sformatf("monitor_k%0d", k), {z_s[k], of_s[k], bo_s[k], res_s[k]}, exp_q[k][0]);
            if (ordy[k]) void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  // Present operands until accepted, then scramble inputs (must be ignored)
  task automatic send(int k, logic [63:0] a, logic [63:0] b, logic bin);
    bit acc;
    acc = 1'b0;
    a_s[k] = a; b_s[k] = b; bin_s[k] = bin; iv[k] = 1'b1;
    for (int c = 0; c < 400 && !acc; c++) begin
      @(negedge clk);
      acc = ir_s[k];
      @(posedge clk);
      #1;
    end
    iv[k] = 1'b0;
    a_s[k] = {$urandom, $urandom};
    b_s[k] = {$urandom, $urandom};
    bin_s[k] = 1'($urandom);
    if (acc) exp_q[k].push_back(model(width_of(k), a, b, bin));
    else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout k=%0d: in_ready actual=0 required=1", k);
    end
  endtask

  task automatic wait_valid(int k, output int cyc);
    cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (ov_s[k]) begin
        cyc = c;
        break;
      end
    end
    if (cyc == 0) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout k=%0d: out_valid actual=0 required=1", k);
    end
  endtask

  task automatic wait_drop(int k);
    bit dropped;
    dropped = 1'b0;
    for (int c = 0; c < 200 && !dropped; c++) begin
      @(posedge clk);
      #1;
      dropped = !ov_s[k];
    end
    chk($sformatf("drop_k%0d", k), 68'(ov_s[k]), 68'd0);
  endtask

  // Directed vector with literal expectations and exact latency
  task automatic direct(string name, int k, logic [63:0] a, logic [63:0] b, logic bin,
                        logic [63:0] er, logic eb, logic eo, logic ez);
    int cyc;
    mode[k] = 2;
    send(k, a, b, bin);
    wait_valid(k, cyc);
    chk({name, "_latency"}, 68'(cyc), 68'(width_of(k) / 4));
    chk(name, {z_s[k], of_s[k], bo_s[k], res_s[k]}, {ez, eo, eb, er});
    chk({name, "_in_ready"}, 68'(ir_s[k]), 68'd0);
    mode[k] = 0;
    wait_drop(k);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit drained;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; mode[k] = 0; a_s[k] = '0; b_s[k] = '0; bin_s[k] = 1'b0;
    end

    // Model pins against hand-computed values
    chk("model_35_12", model(8, 64'h35, 64'h12, 1'b0), {3'b000, 64'h23});
    chk("model_00_01", model(8, 64'h00, 64'h01, 1'b0), {3'b001, 64'hFF});
    chk("model_80_01", model(8, 64'h80, 64'h01, 1'b0), {3'b010, 64'h7F});
    chk("model_5_5_1", model(64, 64'd5, 64'd5, 1'b1), {3'b001, 64'hFFFF_FFFF_FFFF_FFFF});

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state_k%0d", k),
          {ov_s[k], ir_s[k], busy_s[k], bo_s[k], of_s[k], z_s[k], res_s[k]},
          {6'b010000, 64'd0});
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed arithmetic vectors
    direct("sub_35_12", 1, 64'h35, 64'h12, 1'b0, 64'h23, 1'b0, 1'b0, 1'b0);
    direct("sub_00_01", 1, 64'h00, 64'h01, 1'b0, 64'hFF, 1'b1, 1'b0, 1'b0);
    direct("sub_80_01", 1, 64'h80, 64'h01, 1'b0, 64'h7F, 1'b0, 1'b1, 1'b0);
    direct("eq64", 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0,
           64'd0, 1'b0, 1'b0, 1'b1);
    direct("bin_all_ones", 0, 64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    direct("w4_8_1", 2, 64'h8, 64'h1, 1'b0, 64'h7, 1'b0, 1'b1, 1'b0);
    direct("w4_3_9_bin", 2, 64'h3, 64'h9, 1'b1, 64'h9, 1'b1, 1'b1, 1'b0);

    // Stall in DONE for 5 cycles: result held, in_ready low
    mode[1] = 2;
    send(1, 64'hA7, 64'h3C, 1'b1);
    wait_valid(1, cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_hold", {ov_s[1], ir_s[1], z_s[1], of_s[1], bo_s[1], res_s[1]},
          {5'b10010, 64'h6A});
    end
    mode[1] = 0;
    wait_drop(1);

    // out_ready and in_valid together in DONE: accept only on the next edge
    mode[1] = 2;
    send(1, 64'h10, 64'h20, 1'b0);
    wait_valid(1, cyc);
    chk("pre_sim_result", {z_s[1], of_s[1], bo_s[1], res_s[1]}, {3'b001, 64'hF0});
    a_s[1] = 64'h44; b_s[1] = 64'h04; bin_s[1] = 1'b1; iv[1] = 1'b1;
    mode[1] = 0;
    @(posedge clk);
    #1;
    chk("sim_no_bypass", {ov_s[1], ir_s[1], busy_s[1]}, 68'b010);
    @(posedge clk);
    #1;
    chk("sim_accept_next", {ov_s[1], ir_s[1], busy_s[1]}, 68'b001);
    iv[1] = 1'b0;
    exp_q[1].push_back(model(8, 64'h44, 64'h04, 1'b1));
    wait_valid(1, cyc);
    chk("sim_result", {z_s[1], of_s[1], bo_s[1], res_s[1]}, {3'b000, 64'h3F});
    wait_drop(1);

    // Reset mid-RUN after digit 3 of 16
    a_s[0] = 64'hFEDC_BA98_7654_3210; b_s[0] = 64'h1111_1111_1111_1111; bin_s[0] = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrun_busy", 68'(busy_s[0]), 68'd1);
    reset = 1'b1;
    #1;
    chk("reset_abort", {ov_s[0], ir_s[0], busy_s[0], res_s[0]}, {3'b010, 64'd0});
    @(posedge clk);
    #1;
    reset = 1'b0;
    direct("after_reset", 0, 64'hFEDC_BA98_7654_3210, 64'h1111_1111_1111_1111, 1'b0,
           64'hEDCB_A987_6543_20FF, 1'b0, 1'b0, 1'b0);

    // Random operands with random output stalls on all three widths
    fork
      begin
        mode[0] = 1;
        for (int i = 0; i < 300; i++)
          send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      end
      begin
        mode[1] = 1;
        for (int i = 0; i < 1000; i++)
          send(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      end
      begin
        mode[2] = 1;
        for (int i = 0; i < 1000; i++)
          send(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      end
    join
    for (int k = 0; k < 3; k++) mode[k] = 0;
    drained = 1'b0;
    for (int c = 0; c < 500 && !drained; c++) begin
      @(posedge clk);
      #1;
      drained = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
    end
    chk("drain", 68'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 68'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
